// File: rtl/imm_pkg.sv
// Shared definitions for the RV32I instruction encoder: formats, opcodes, NOP,
// and the stage-1 register layout.
package imm_pkg;

    // Instruction formats as seen by the encoder. ISH is the shift-immediate
    // flavour of I, where instr[31:25] carries funct7 instead of imm[11:5].
    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_ISH  = 3'd2,
        FMT_S    = 3'd3,
        FMT_B    = 3'd4,
        FMT_U    = 3'd5,
        FMT_J    = 3'd6,
        FMT_RSVD = 3'd7
    } fmt_e;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    // addi x0, x0, 0 -- emitted for the reserved format.
    localparam logic [31:0] NOP = 32'h0000_0013;

    // Request as held in stage 1, with its range-check verdict.
    typedef struct packed {
        fmt_e        fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic        err;
    } s1_t;

endpackage

// File: rtl/imm_encoder_if.sv
// Request/response bus of the instruction encoder.
//
// Handshake: on each side a transfer happens at a rising clk edge where valid
// and ready are both high. The producer holds valid and its payload steady
// until that edge; valid never waits on ready. The encoder is the slave on
// both sides: it receives requests (in_*) and presents words (out_*).
interface imm_encoder_if;
    import imm_pkg::*;

    logic        in_valid;
    logic        in_ready;
    fmt_e        in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;

    modport slave (
        input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_err
    );

    modport master (
        output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_err
    );

endinterface

// File: rtl/imm_range_chk.sv
// Flags immediates that cannot be represented exactly in the given format.
module imm_range_chk
    import imm_pkg::*;
(
    input  fmt_e        fmt,
    input  logic [31:0] imm,
    output logic        err
);

    // Signed formats need the bits above the top encoded bit to be a pure
    // sign extension; B and J additionally cannot encode bit 0.
    always_comb begin
        err = 1'b0;
        case (fmt)
            FMT_R:        err = 1'b0;
            FMT_I, FMT_S: err = !((&imm[31:11]) || !(|imm[31:11]));
            FMT_B:        err = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
            FMT_J:        err = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
            FMT_U:        err = |imm[11:0];
            FMT_ISH:      err = |imm[31:5];
            default:      err = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage RV32I instruction encoder: stage 1 registers the request and
// range-checks the immediate, stage 2 scatters the immediate bits into the
// instruction word. Counts emitted words and emitted error words.
module imm_encoder
    import imm_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    imm_encoder_if.slave     bus,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic        s1_valid;
    s1_t         s1;
    logic        chk_err;
    logic        s2_ready;
    logic        out_fire;
    logic [31:0] instr_d;

    imm_range_chk u_range_chk (
        .fmt (bus.in_fmt),
        .imm (bus.in_imm),
        .err (chk_err)
    );

    // The output register can take a new word when empty or draining; stage 1
    // can then shift forward, so in_ready sees out_ready combinationally.
    assign s2_ready     = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = reset || !s1_valid || s2_ready;
    assign out_fire     = bus.out_valid && bus.out_ready;

    // Stage 1: capture the request and its range verdict.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else if (bus.in_ready) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1 <= '{fmt:    bus.in_fmt,
                        opcode: bus.in_opcode,
                        rd:     bus.in_rd,
                        rs1:    bus.in_rs1,
                        rs2:    bus.in_rs2,
                        funct3: bus.in_funct3,
                        funct7: bus.in_funct7,
                        imm:    bus.in_imm,
                        err:    chk_err};
            end
        end
    end

    // Stage 2 datapath: place each field; out-of-range immediates are simply
    // truncated to the bits the format carries.
    always_comb begin
        instr_d = NOP;
        case (s1.fmt)
            FMT_R:   instr_d = {s1.funct7, s1.rs2, s1.rs1, s1.funct3, s1.rd, s1.opcode};
            FMT_I:   instr_d = {s1.imm[11:0], s1.rs1, s1.funct3, s1.rd, s1.opcode};
            FMT_ISH: instr_d = {s1.funct7, s1.imm[4:0], s1.rs1, s1.funct3, s1.rd, s1.opcode};
            FMT_S:   instr_d = {s1.imm[11:5], s1.rs2, s1.rs1, s1.funct3, s1.imm[4:0], s1.opcode};
            FMT_B:   instr_d = {s1.imm[12], s1.imm[10:5], s1.rs2, s1.rs1, s1.funct3,
                                s1.imm[4:1], s1.imm[11], s1.opcode};
            FMT_U:   instr_d = {s1.imm[31:12], s1.rd, s1.opcode};
            FMT_J:   instr_d = {s1.imm[20], s1.imm[10:1], s1.imm[11], s1.imm[19:12],
                                s1.rd, s1.opcode};
            default: instr_d = NOP;
        endcase
    end

    // Stage 2 register: load only when free, so a stalled word holds steady.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.out_instr <= '0;
            bus.out_err   <= 1'b0;
        end else if (s2_ready) begin
            bus.out_valid <= s1_valid;
            if (s1_valid) begin
                bus.out_instr <= instr_d;
                bus.out_err   <= s1.err;
            end
        end
    end

    // Saturating counters of accepted output words.
    always_ff @(posedge clk) begin
        if (reset) begin
            enc_count <= '0;
            err_count <= '0;
        end else if (out_fire) begin
            if (enc_count != '1) enc_count <= enc_count + CNT_ONE;
            if (bus.out_err && (err_count != '1)) err_count <= err_count + CNT_ONE;
        end
    end

endmodule
